// File: rtl/shift_sched.sv
// shift_sched: two-port round-robin scheduler around one iterative log-stage
// 32-bit shifter. Each operation walks stages 16,8,4,2,1 one per cycle and
// completes with a one-cycle done pulse carrying the result and owner id.
module shift_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [4:0]  shamt0,
    input  logic [4:0]  shamt1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  sh_q, sh_d;
    logic [1:0]  op_q, op_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic [31:0] result_q, result_d;

    logic        win;
    logic [4:0]  stage_amt;
    logic [31:0] shifted;
    logic [31:0] stage_val;

    // Arbitration and one barrel stage; stage width is 2^k for the current k.
    always_comb begin
        // a lone request wins outright; on a tie the port not served last wins
        win       = (req == 2'b11) ? ~last_q : req[1];
        stage_amt = 5'd1 << k_q;
        case (op_q)
            2'b00:   shifted = acc_q << stage_amt;
            2'b01:   shifted = acc_q >> stage_amt;
            default: shifted = $unsigned($signed(acc_q) >>> stage_amt);
        endcase
        stage_val = sh_q[k_q] ? shifted : acc_q;
    end

    // Next-state logic: capture in IDLE/DONE, one stage per cycle in SHIFT.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        op_d      = op_q;
        owner_d   = owner_q;
        last_d    = last_q;
        grant_d   = 2'b00;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        case (state_q)
            S_SHIFT: begin
                acc_d = stage_val;
                if (k_q == 3'd0) begin
                    result_d  = stage_val;
                    done_id_d = owner_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            default: begin
                // IDLE and DONE both capture, giving back-to-back operation
                if (|req) begin
                    acc_d   = win ? in1 : in0;
                    sh_d    = win ? shamt1 : shamt0;
                    op_d    = win ? op1 : op0;
                    owner_d = win;
                    last_d  = win;
                    grant_d = win ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    k_d     = 3'd4;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= 3'd4;
            acc_q     <= 32'd0;
            sh_q      <= 5'd0;
            op_q      <= 2'b00;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            op_q      <= op_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule

// File: doc/shift_sched.md
# shift_sched

Multi-cycle shift scheduler that shares one iterative log-stage shifter between two requesters (port 0: ALU, port 1: multiply/divide unit). Each operation is executed one barrel stage per cycle, in the order 16, 8, 4, 2, 1. Requests are arbitrated round-robin, accepted with a one-cycle grant pulse, and completed with a one-cycle `done` pulse carrying the result and the requester id. The block replaces a dedicated 32-bit combinational shifter per client where area matters more than latency.

## Interface
Parameters:
- None. Data width is fixed at 32 and shift amount at 5 bits.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 2: `req[i]` is a level request from port i.
- `in0`, `in1` in 32 each: operand for each port.
- `shamt0`, `shamt1` in 5 each: shift amount for each port.
- `op0`, `op1` in 2 each: operation select. 00 = SLL, 01 = SRL, 1x = SRA.
- `grant` out 2: one-hot, one-cycle pulse marking the port whose operands were captured.
- `busy` out 1: high from the capture edge until the edge that raises `done`.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: port that owns the current or last result.
- `result` out 32: shifted value. Valid while `done` is high and held until the next `done`.

## Operation
- State machine: IDLE, SHIFT, DONE. A 3-bit stage counter `k` is used in SHIFT.
- Capture happens in IDLE or DONE on any edge where `req != 0`:
  - Latch the winner's operand, shamt and op into internal registers `acc`, `sh`, `op`.
  - Register `grant[winner]=1` for the next cycle and set `busy=1`.
  - Move to SHIFT with `k=4`.
- Arbitration:
  - If exactly one `req` bit is high, that port wins.
  - If both are high, the winner is the port not equal to `last`.
  - `last` updates to the winner at each capture. `last` resets to 1, so port 0 wins the first tie.
- SHIFT, on each edge:
  - If `sh[k]` is set, shift `acc` by 2^k per `op`. Otherwise hold `acc`.
  - SLL zero-fills from the LSB. SRL zero-fills from the MSB. SRA fills with `acc[31]` as captured.
  - Only the low 32 bits are kept; bits shifted out are discarded.
  - If `k==0`: write `result <= shifted acc`, `done_id <= owner`, `done <= 1`, `busy <= 0`, and move to DONE. Otherwise `k <= k-1`.
- DONE lasts exactly one cycle:
  - `done` drops on the next edge.
  - A request present on that edge is captured (back-to-back operation). Otherwise the state returns to IDLE.
- Fixed-latency rule: shamt 0 still takes all 5 stage cycles and returns the operand unchanged.
- Request protocol:
  - A requester holds `req`, operands, shamt and op stable until it sees its `grant` bit.
  - It drops `req` in the grant cycle unless it wants another operation.
  - A `req` still high at a capture edge is treated as a new request.
  - The non-winning request remains pending and is served next.
- `req` is ignored while in SHIFT.
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, `k=4`, `grant=0`, `busy=0`, `done=0`, `done_id=0`, `result=0`, `last=1`, `acc=0`.
  - An in-flight operation is dropped with no `done` pulse.

## Timing
- Capture at edge E0. `grant` and `busy` are high during cycle E0..E1.
- Stages 16/8/4/2/1 are applied at edges E1..E5.
- `done` and `result` are valid during E5..E6. `busy` falls at E5.
- Latency is 5 cycles from capture edge to `done`. Peak throughput is one operation per 6 cycles (re-capture allowed at E6).
- `grant`, `busy`, `done`, `done_id` and `result` are all registered, with no combinational paths from inputs to outputs.
- After `reset` deasserts, the first capture can occur on the first rising edge.

## Test plan
- **SLL**: `req=01`, `in0=0x00000001`, `shamt0=31`, `op0=00` → `grant=01` one cycle after capture; `done=1`, `done_id=0`, `result=0x80000000` exactly 5 edges after capture.
- **SRA / SRL**: port 1, `in1=0x80000000`, `shamt1=4`, `op1=10` → `result=0xF8000000`, `done_id=1`. Repeat with `op1=01` → `result=0x08000000`.
- **Tie and round-robin**: both ports request from reset, held until granted → port 0 granted first; port 1 captured at the DONE edge (6 cycles later); the two `done` pulses are 6 cycles apart and their results match the respective operands.
- **Zero shift**: `in0=0xDEADBEEF`, `shamt0=0` → `result=0xDEADBEEF` after full 5-cycle latency; `busy` is high for exactly 5 cycles.
- **Reset mid-operation**: assert `reset` at edge E3 of an operation → all outputs 0 immediately and no `done` pulse. A new request after release completes normally, with port 0 winning any tie.
- **Held request**: hold `req=01` continuously → a new operation is captured every 6 cycles, `done` pulses every 6 cycles, and `result` holds its value between pulses.
